if_id_queue: RTL and testbench

IF_ID_QUEUE -- requirements
Module: if_id_queue

---
 rtl/if_id_queue.sv | 87 ++++++++
 tb/tb_if_id_queue.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: a DEPTH-entry FIFO of {inst, pc, pc_plus_4}
// triples with flush, one-cycle latency and zeroed (NOP) outputs when empty.
module if_id_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_inst,
    input  logic [WIDTH-1:0]           in_pc,
    input  logic [WIDTH-1:0]           in_pc_plus_4,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_inst,
    output logic [WIDTH-1:0]           out_pc,
    output logic [WIDTH-1:0]           out_pc_plus_4,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] inst_mem [DEPTH];
    logic [WIDTH-1:0] pc_mem   [DEPTH];
    logic [WIDTH-1:0] pc4_mem  [DEPTH];

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          push;
    logic          pop;

    // No pass-through when full: in_ready looks only at occupancy.
    assign in_ready  = (count_reg != CW'(DEPTH));
    assign out_valid = (count_reg != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign count     = count_reg;

    // Storage carries no reset; visible zeros come from out_valid gating.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr_reg] <= in_inst;
            pc_mem[wr_ptr_reg]   <= in_pc;
            pc4_mem[wr_ptr_reg]  <= in_pc_plus_4;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    always_comb begin
        out_inst      = '0;
        out_pc        = '0;
        out_pc_plus_4 = '0;
        if (out_valid) begin
            out_inst      = inst_mem[rd_ptr_reg];
            out_pc        = pc_mem[rd_ptr_reg];
            out_pc_plus_4 = pc4_mem[rd_ptr_reg];
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue (WIDTH=32, DEPTH=4) with hand-computed expectations.
module tb_if_id_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic [31:0] in_pc_plus_4;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus_4;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;

    if_id_queue #(.WIDTH(32), .DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_inst      (in_inst),
        .in_pc        (in_pc),
        .in_pc_plus_4 (in_pc_plus_4),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_inst     (out_inst),
        .out_pc       (out_pc),
        .out_pc_plus_4(out_pc_plus_4),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%08h", tag, got);
        end
    endtask

    // Inputs change 1 time unit after each rising edge and are sampled there too.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] inst, input logic [31:0] pc);
        in_valid     = v;
        in_inst      = inst;
        in_pc        = pc;
        in_pc_plus_4 = pc + 32'd4;
    endtask

    initial begin
        logic [31:0] exp_head;
        logic [31:0] next_push;

        rst = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        set_in(1'b0, 32'h0, 32'h0);
        #12;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_count", {29'b0, count}, 32'd0);
        check("rst_out_inst", out_inst, 32'd0);
        check("rst_out_pc4", out_pc_plus_4, 32'd0);
        rst = 1'b1;

        // Basic push after reset
        set_in(1'b1, 32'h00500093, 32'h0);
        tick();
        set_in(1'b0, 32'h0, 32'h0);
        check("basic_out_valid", {31'b0, out_valid}, 32'd1);
        check("basic_out_inst", out_inst, 32'h00500093);
        check("basic_out_pc", out_pc, 32'h0);
        check("basic_out_pc4", out_pc_plus_4, 32'h4);
        check("basic_count", {29'b0, count}, 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("basic_pop_count", {29'b0, count}, 32'd0);
        check("basic_pop_zero", out_inst, 32'd0);

        // Fill with stall: five offers, only four accepted, head fixed
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 32'h100 + i, 32'h1000 + 4 * i);
            tick();
            check($sformatf("fill%0d_count", i), {29'b0, count}, (i < 4) ? i + 1 : 4);
            check($sformatf("fill%0d_in_ready", i), {31'b0, in_ready}, (i < 3) ? 32'd1 : 32'd0);
            check($sformatf("fill%0d_head", i), out_inst, 32'h100);
        end
        set_in(1'b0, 32'h0, 32'h0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d_inst", i), out_inst, 32'h100 + i);
            check($sformatf("drain%0d_pc4", i), out_pc_plus_4, 32'h1004 + 4 * i);
            tick();
        end
        out_ready = 1'b0;
        check("drain_count", {29'b0, count}, 32'd0);
        check("drain_out_valid", {31'b0, out_valid}, 32'd0);

        // Steady flow at occupancy 2; pointers wrap several times
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 32'h200 + i, 32'h2000 + 4 * i);
            tick();
        end
        exp_head  = 32'h200;
        next_push = 32'h202;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            set_in(1'b1, next_push, 32'h2000 + 4 * (next_push - 32'h200));
            check($sformatf("flow%0d_head", k), out_inst, exp_head);
            tick();
            check($sformatf("flow%0d_count", k), {29'b0, count}, 32'd2);
            exp_head  = exp_head + 1;
            next_push = next_push + 1;
        end
        check("flow_last_pc", out_pc, 32'h2000 + 4 * (exp_head - 32'h200));

        // Flush priority with concurrent push and pop at count 3
        out_ready = 1'b0;
        set_in(1'b1, 32'h300, 32'h3000);
        tick();
        check("pre_flush_count", {29'b0, count}, 32'd3);
        flush = 1'b1;
        out_ready = 1'b1;
        set_in(1'b1, 32'hDEAD, 32'hD000);
        tick();
        flush = 1'b0;
        out_ready = 1'b0;
        set_in(1'b0, 32'h0, 32'h0);
        check("flush_count", {29'b0, count}, 32'd0);
        check("flush_out_valid", {31'b0, out_valid}, 32'd0);
        check("flush_out_inst", out_inst, 32'd0);
        check("flush_out_pc", out_pc, 32'd0);
        set_in(1'b1, 32'h310, 32'h3100);
        tick();
        set_in(1'b0, 32'h0, 32'h0);
        check("post_flush_head", out_inst, 32'h310);
        check("post_flush_count", {29'b0, count}, 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Asynchronous reset between edges with two entries queued
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 32'h400 + i, 32'h4000 + 4 * i);
            tick();
        end
        set_in(1'b0, 32'h0, 32'h0);
        check("pre_arst_count", {29'b0, count}, 32'd2);
        #2;
        rst = 1'b0;
        #1;
        check("arst_count", {29'b0, count}, 32'd0);
        check("arst_out_valid", {31'b0, out_valid}, 32'd0);
        check("arst_in_ready", {31'b0, in_ready}, 32'd1);
        check("arst_out_inst", out_inst, 32'd0);
        #1;
        rst = 1'b1;
        set_in(1'b1, 32'h500, 32'h5000);
        tick();
        set_in(1'b0, 32'h0, 32'h0);
        check("post_arst_head", out_inst, 32'h500);
        check("post_arst_pc", out_pc, 32'h5000);
        check("post_arst_count", {29'b0, count}, 32'd1);
        out_ready = 1'b1;
        tick();

        // Pops against an empty queue must be ignored
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("empty_pop%0d_count", i), {29'b0, count}, 32'd0);
            check($sformatf("empty_pop%0d_valid", i), {31'b0, out_valid}, 32'd0);
        end
        out_ready = 1'b0;
        set_in(1'b1, 32'h600, 32'h60);
        tick();
        set_in(1'b0, 32'h0, 32'h0);
        check("empty_push_inst", out_inst, 32'h600);
        check("empty_push_pc", out_pc, 32'h60);
        check("empty_push_pc4", out_pc_plus_4, 32'h64);
        check("empty_push_count", {29'b0, count}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
